// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request in flight to a
// variable-latency instruction memory and buffers one instruction for decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect_e,
  input  logic [63:0] redirect_pc_e,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_f,
  output logic [63:0] pc_f,
  output logic [31:0] instr_f
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [63:0] pc_f_q, pc_f_d;
  logic [31:0] instr_buf_q, instr_buf_d;

  logic        consume;
  logic        issue_ok;
  logic [63:0] redirect_target;
  logic        unused_low_bits;

  assign consume         = valid_q & ~stall_f;
  assign redirect_target = {redirect_pc_e[63:2], 2'b00};
  assign unused_low_bits = ^redirect_pc_e[1:0];

  // Issuing only into an empty (or emptying) buffer means a response never
  // finds the buffer occupied, so no skid storage is needed.
  assign issue_ok = (state_q == S_ISSUE) & ~redirect_e & (~valid_q | consume);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    pc_f_d      = pc_f_q;
    instr_buf_d = instr_buf_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    if (redirect_e) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_ISSUE : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_ISSUE : S_DROP;
        default: state_d = S_ISSUE;
      endcase
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (issue_ok) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            valid_d     = 1'b1;
            pc_f_d      = pc_q;
            instr_buf_d = imem_rdata;
            pc_d        = pc_q + 64'd4;
            state_d     = S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      pc_f_q      <= 64'h0;
      instr_buf_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      pc_f_q      <= pc_f_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  assign imem_req  = issue_ok & ~rst;
  assign imem_addr = pc_q;
  assign valid_f   = valid_q;
  assign pc_f      = pc_f_q;
  assign instr_f   = valid_q ? instr_buf_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with per-request latency plus a
// program-order model (expected fetch address and expected delivered PC stream).
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        redirect_e = 1'b0;
  logic [63:0] redirect_pc_e = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid_f;
  logic [63:0] pc_f;
  logic [31:0] instr_f;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .redirect_e(redirect_e),
    .redirect_pc_e(redirect_pc_e), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_f(valid_f),
    .pc_f(pc_f), .instr_f(instr_f)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // memory responder state
  bit          pend = 0;
  int          cnt = 0;
  logic [63:0] paddr = 64'h0;
  int          lat = 1;

  // program-order model
  logic [63:0] nf = RESET_PC;
  logic [63:0] exp_pc = RESET_PC;
  bit          hold_prev = 0;
  logic [63:0] hold_pc = 64'h0;
  logic [31:0] hold_instr = 32'h0;
  int          consumed = 0;

  // samples of the last cycle
  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    if (a == 64'h4) return 32'h00A00113;
    return a[33:2] ^ a[63:32] ^ 32'h5A5A_0003;
  endfunction

  task automatic model_reset();
    pend = 0; cnt = 0; nf = RESET_PC; exp_pc = RESET_PC; hold_prev = 0;
  endtask

  // One clock cycle: drive inputs, sample outputs, check invariants, clock, update model.
  task automatic cycle(input bit stall, input bit redir, input logic [63:0] tgt, input bit stale);
    logic [63:0] t;
    bit rv;
    t  = {tgt[63:2], 2'b00};
    rv = stale | (pend && cnt == 0);
    stall_f = stall; redirect_e = redir; redirect_pc_e = tgt;
    imem_rvalid = rv; imem_rdata = stale ? 32'hDEAD_BEEF : mem(paddr);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = valid_f; s_pc = pc_f; s_instr = instr_f;

    if (!s_valid) begin
      total++;
      if (s_instr !== NOP) begin bad++; $display("FAIL nop_when_empty: got %h want %h", s_instr, NOP); end
    end
    if (redir) begin
      total++;
      if (s_req !== 1'b0) begin bad++; $display("FAIL req_on_redirect: got %b want 0", s_req); end
    end
    if (s_valid && stall) begin
      total++;
      if (s_req !== 1'b0) begin bad++; $display("FAIL req_while_stalled: got %b want 0", s_req); end
    end
    if (s_req) begin
      total++;
      if (pend) begin bad++; $display("FAIL one_outstanding: req while pending addr %h", paddr); end
      total++;
      if (s_addr !== nf) begin bad++; $display("FAIL req_addr: got %h want %h", s_addr, nf); end
    end
    if (s_valid) begin
      total++;
      if (s_pc !== exp_pc) begin bad++; $display("FAIL pc_stream: got %h want %h", s_pc, exp_pc); end
      total++;
      if (s_instr !== mem(s_pc)) begin bad++; $display("FAIL instr_data: got %h want %h", s_instr, mem(s_pc)); end
    end
    if (hold_prev) begin
      total++;
      if (s_valid !== 1'b1 || s_pc !== hold_pc || s_instr !== hold_instr)
        begin bad++; $display("FAIL stall_hold: got %b/%h/%h want 1/%h/%h", s_valid, s_pc, s_instr, hold_pc, hold_instr); end
    end

    @(posedge clk); #1;

    if (rv && !stale) pend = 0;
    else if (pend && cnt > 0) cnt--;
    if (s_req === 1'b1) begin pend = 1; paddr = s_addr; cnt = lat - 1; end
    if (redir) begin nf = t; exp_pc = t; end
    else if (s_valid && !stall) begin exp_pc = exp_pc + 64'd4; consumed++; end
    if (s_req === 1'b1) nf = s_addr + 64'd4;
    hold_prev  = s_valid && stall && !redir;
    hold_pc    = s_pc;
    hold_instr = s_instr;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_f = 0; redirect_e = 0; imem_rvalid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_f = 0; redirect_e = 0; imem_rvalid = 0;
    @(posedge clk); #3;
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_f); end
    total++; if (pc_f !== 64'h0) begin bad++; $display("FAIL reset_pc_f: got %h want 0", pc_f); end
    total++; if (instr_f !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", instr_f, NOP); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset(); lat = 1;
    cycle(0, 0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h0) begin bad++; $display("FAIL basic_req0: got %b/%h want 1/0", s_req, s_addr); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_instr !== 32'h00500093)
      begin bad++; $display("FAIL basic_out0: got %b/%h/%h want 1/0/00500093", s_valid, s_pc, s_instr); end
    total++; if (s_req !== 1'b1 || s_addr !== 64'h4) begin bad++; $display("FAIL basic_req4: got %b/%h want 1/4", s_req, s_addr); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h4 || s_instr !== 32'h00A00113)
      begin bad++; $display("FAIL basic_out4: got %b/%h/%h want 1/4/00A00113", s_valid, s_pc, s_instr); end
  endtask

  task automatic test_stall();
    do_reset(); lat = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0);
      total++; if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_instr !== 32'h00500093 || s_req !== 1'b0)
        begin bad++; $display("FAIL stall_cycle%0d: got %b/%h/%h req=%b want 1/0/00500093 req=0", i, s_valid, s_pc, s_instr, s_req); end
    end
    cycle(0, 0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h4) begin bad++; $display("FAIL stall_release_req: got %b/%h want 1/4", s_req, s_addr); end
  endtask

  task automatic test_redirect_drop();
    bit seen;
    do_reset(); lat = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 64'h100, 0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle(0, 0, 0, 0);
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b want 0", s_valid); end
      if (s_req === 1'b1) begin
        seen = 1;
        total++; if (s_addr !== 64'h100) begin bad++; $display("FAIL drop_next_addr: got %h want 100", s_addr); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL drop_timeout: got no req want req"); end
  endtask

  task automatic test_simultaneous();
    do_reset(); lat = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 64'h200, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 64'h200)
      begin bad++; $display("FAIL redirect_rvalid: got %b/%b/%h want 0/1/200", s_valid, s_req, s_addr); end
    cycle(0, 0, 0, 0);
    cycle(1, 1, 64'h300, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h200) begin bad++; $display("FAIL pre_redirect_buf: got %b/%h want 1/200", s_valid, s_pc); end
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b0 || s_instr !== NOP || s_req !== 1'b1 || s_addr !== 64'h300)
      begin bad++; $display("FAIL redirect_stall: got %b/%h/%b/%h want 0/%h/1/300", s_valid, s_instr, s_req, s_addr, NOP); end
  endtask

  task automatic test_async_reset();
    do_reset(); lat = 1;
    repeat (4) cycle(0, 0, 0, 0);
    lat = 3;
    cycle(0, 0, 0, 0);
    total++; if (pc_f !== 64'h4 || s_req !== 1'b1) begin bad++; $display("FAIL pre_rst_state: got %h/%b want 4/1", pc_f, s_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (valid_f !== 1'b0 || instr_f !== NOP || pc_f !== 64'h0 || imem_req !== 1'b0)
      begin bad++; $display("FAIL async_rst: got %b/%h/%h/%b want 0/%h/0/0", valid_f, instr_f, pc_f, imem_req, NOP); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset(); lat = 1;
    cycle(0, 0, 0, 1);
    total++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin bad++; $display("FAIL post_rst_req: got %b/%h want 1/%h", s_req, s_addr, RESET_PC); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_instr !== 32'h00500093) begin bad++; $display("FAIL stale_ignored: got %b/%h want 1/00500093", s_valid, s_instr); end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1;
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_req: got %b/%h want 1/fffffffffffffffc", s_req, s_addr); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_buf: got %b/%h want 1/fffffffffffffffc", s_valid, s_pc); end
    total++; if (s_req !== 1'b1 || s_addr !== 64'h0) begin bad++; $display("FAIL wrap_next: got %b/%h want 1/0", s_req, s_addr); end
  endtask

  task automatic test_random();
    int start;
    logic [63:0] tgt;
    do_reset();
    start = consumed;
    for (int i = 0; i < 3000; i++) begin
      lat = 1 + int'($urandom_range(0, 3));
      tgt = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {32'h0, $urandom};
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, tgt, 0);
    end
    total++; if (consumed - start < 50) begin bad++; $display("FAIL random_progress: got %0d want >=50", consumed - start); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_drop();
    test_simultaneous();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
